// File: rtl/stack_pkg.sv
// stack_pkg: shared defaults and width helpers for the parameterised stack.
//   DATA_W_DEF : default entry width in bits
//   DEPTH_DEF  : default number of entries (power of two, 2..256)
//   ptr_w()    : count/pointer width wide enough to hold the value DEPTH
package stack_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 32;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stack_mem.sv
// stack_mem: storage array for param_stack.
//   clk, rst_n : clock, asynchronous active-low reset (zeroes every entry)
//   we         : write enable for the synchronous write port
//   clr        : with we, write zero instead of wdata
//   waddr      : write address
//   wdata      : write data
//   raddr      : asynchronous read address
//   rdata      : asynchronous read data
module stack_mem #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned AW     = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              clr,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= clr ? '0 : wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// param_stack: LIFO stack with registered result port and sticky error flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : operand for push
//   push       : push data_in
//   pop        : remove and return top entry (with push: replace top)
//   tos        : return top entry without removing it
//   clr_err    : clear overflow/underflow (a new error in the same cycle wins)
//   res_stk    : registered result of pop/tos
//   res_valid  : one-cycle strobe, res_stk updated this cycle
//   count      : number of stored entries
//   full/empty : count == DEPTH / count == 0
//   overflow   : sticky, a push was rejected
//   underflow  : sticky, a pop or tos was rejected
module param_stack
   import stack_pkg::*;
#(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   parameter  int unsigned DEPTH  = DEPTH_DEF,
   localparam int unsigned PTR_W  = ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              push,
   input  logic              pop,
   input  logic              tos,
   input  logic              clr_err,
   output logic [DATA_W-1:0] res_stk,
   output logic              res_valid,
   output logic [PTR_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned AW = PTR_W - 1;

   logic [AW-1:0]     top_addr;
   logic [DATA_W-1:0] top_data;
   logic              mem_we;
   logic              mem_clr;
   logic [AW-1:0]     mem_waddr;
   logic [PTR_W-1:0]  count_nxt;
   logic              valid_nxt;
   logic              ovf_set;
   logic              unf_set;

   assign full     = (count == PTR_W'(DEPTH));
   assign empty    = (count == '0);
   assign top_addr = AW'(count - PTR_W'(1));

   stack_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .clr   (mem_clr),
      .waddr (mem_waddr),
      .wdata (data_in),
      .raddr (top_addr),
      .rdata (top_data)
   );

   // tos dominates; pop covers both plain pop and push+pop replace.
   always_comb begin
      count_nxt = count;
      valid_nxt = 1'b0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      mem_we    = 1'b0;
      mem_clr   = 1'b0;
      mem_waddr = top_addr;
      if (tos) begin
         if (empty) unf_set = 1'b1;
         else       valid_nxt = 1'b1;
      end else if (pop) begin
         if (empty) begin
            unf_set = 1'b1;
         end else begin
            valid_nxt = 1'b1;
            mem_we    = 1'b1;
            mem_clr   = !push;
            if (!push) count_nxt = count - PTR_W'(1);
         end
      end else if (push) begin
         if (full) begin
            ovf_set = 1'b1;
         end else begin
            mem_we    = 1'b1;
            mem_waddr = AW'(count);
            count_nxt = count + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         res_stk   <= '0;
         res_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= count_nxt;
         res_valid <= valid_nxt;
         if (valid_nxt) res_stk <= top_data;
         overflow  <= ovf_set | (overflow  & !clr_err);
         underflow <= unf_set | (underflow & !clr_err);
      end
   end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter DATA_W, default 8: width of each stack entry in bits.
REQ-002 Parameter DEPTH, default 32: number of entries; any power of two from 2 to 256.
REQ-003 Derived constant PTR_W = log2(DEPTH)+1: pointer/count width, so that count can reach DEPTH.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  DATA_W  operand for push.
REQ-007 push  input  1  write data_in onto the stack.
REQ-008 pop  input  1  remove the top entry and return it.
REQ-009 tos  input  1  read the top entry without removing it.
REQ-010 clr_err  input  1  clear the sticky error flags.
REQ-011 res_stk  output  DATA_W  registered result of pop or tos.
REQ-012 res_valid  output  1  one-cycle strobe; res_stk was updated this cycle.
REQ-013 count  output  PTR_W  current number of stored entries.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 overflow  output  1  sticky flag: push was rejected.
REQ-017 underflow  output  1  sticky flag: pop or tos was rejected.

Function
REQ-018 The block SHALL sample all commands on the rising clk edge, and all outputs SHALL be registered, giving a latency of 1 cycle.
REQ-019 Command priority SHALL be: tos, then push+pop together (replace), then pop, then push; a lower-priority command asserted in the same cycle SHALL be ignored without raising an error.
REQ-020 tos with count>0 SHALL load res_stk with the top entry, assert res_valid, and leave count and storage unchanged.
REQ-021 pop with count>0 SHALL load res_stk with the top entry, assert res_valid, and decrement count; the vacated slot SHALL be written to zero.
REQ-022 push with count<DEPTH SHALL store data_in at index count and increment count; res_stk and res_valid SHALL be unaffected.
REQ-023 push and pop together with count>0 SHALL return the old top on res_stk with res_valid asserted, overwrite the top with data_in, and leave count unchanged; this SHALL be legal when full.
REQ-024 push and pop together with count==0 SHALL behave as a rejected pop: underflow is set and nothing is pushed.
REQ-025 push when full SHALL leave storage and count unchanged and set overflow.
REQ-026 pop or tos when empty SHALL leave res_stk unchanged, keep res_valid low, and set underflow.
REQ-027 overflow and underflow SHALL stay set until clr_err is asserted; if clr_err and a new error occur in the same cycle, the error SHALL win.
REQ-028 full and empty SHALL be derived from the registered count and SHALL be valid in the cycle after each update.
REQ-029 count SHALL never wrap: it SHALL never go below 0 or above DEPTH.

Reset
REQ-030 Asserting rst_n low SHALL immediately clear count, res_stk, res_valid, overflow and underflow, and SHALL set empty=1 and full=0.
REQ-031 Storage contents SHALL be zeroed on reset.
REQ-032 Reset asserted during any command SHALL override that command; the first command SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-033 The DATA_W and DEPTH default constants and the PTR_W derivation function SHALL live in the shared package stack_pkg.
REQ-034 Storage SHALL be a separate sub-module, stack_mem, with one synchronous write port (with clear) and one asynchronous read port.
REQ-035 Pointer, flag and result logic SHALL reside in param_stack.

Verification
REQ-036 Reset, then push 0x11, 0x22, 0x33, then pop x3 -> res_stk 0x33, 0x22, 0x11 on consecutive cycles with res_valid high; count goes 3,2,1,0; empty=1 at the end.
REQ-037 Push DEPTH values 0..31, then push 0xAA -> full=1, overflow=1, count=32; tos -> res_stk=31.
REQ-038 From empty: pop, then tos -> underflow=1, res_valid stays low, res_stk=0; then clr_err -> underflow=0.
REQ-039 From full, push 0x5A and pop together -> res_stk=31, count stays 32, no overflow; next tos -> 0x5A.
REQ-040 Push 0x01, 0x02, then tos asserted with push 0x03 -> res_stk=0x02, count stays 2.
REQ-041 Push 5 entries, then drop rst_n between clock edges -> count=0 and flags cleared immediately; after release, tos -> underflow=1.
